// File: rtl/complex_magnitude.sv
// Streaming magnitude estimator for packed complex samples.
// Three pipeline stages (abs, max/min, sum) feed an output stage that tags each beat with its bin index.
module complex_magnitude #(
  parameter int N_BINS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_first,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_mag,
  output logic [15:0] out_bin,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err
);

  localparam logic [15:0] LAST_BIN = 16'(N_BINS - 1);

  // |v| limited to 15 bits: the single value with no positive twin is clamped.
  function automatic logic [14:0] abs_sat(input logic [15:0] v);
    logic [15:0] neg;
    neg = 16'(~v + 16'd1);
    if (v == 16'h8000)
      return 15'h7fff;
    else if (v[15])
      return neg[14:0];
    else
      return v[14:0];
  endfunction

  logic        stall;
  logic        advance;
  logic        out_fire;

  logic        s1_valid;
  logic        s1_first;
  logic [14:0] s1_re_abs;
  logic [14:0] s1_im_abs;

  logic        s2_valid;
  logic        s2_first;
  logic [14:0] s2_max;
  logic [14:0] s2_min;

  logic        s3_valid;
  logic        s3_first;
  logic [15:0] s3_mag;

  logic [15:0] bin_cnt;

  // A full output stage that downstream refuses freezes the whole pipe.
  assign stall    = s3_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;
  assign out_fire = s3_valid && out_ready;

  // Control state: valid bits, first flags, output magnitude and bin counter.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s3_valid <= 1'b0;
      s3_first <= 1'b0;
      s3_mag   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_first <= in_valid && in_first;
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s3_valid <= s2_valid;
      s3_first <= s2_first;
      s3_mag   <= {1'b0, s2_max} + {3'b000, s2_min[14:2]};
    end
  end

  // NOTE: intermediate datapath registers carry no reset; their contents are ignored until a valid bit covers them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_re_abs <= abs_sat(in_data[31:16]);
      s1_im_abs <= abs_sat(in_data[15:0]);
      if (s1_re_abs >= s1_im_abs) begin
        s2_max <= s1_re_abs;
        s2_min <= s1_im_abs;
      end else begin
        s2_max <= s1_im_abs;
        s2_min <= s1_re_abs;
      end
    end
  end

  // A first-flagged beat restarts the frame at bin 0; the counter then points at bin 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt <= '0;
    end else if (out_fire) begin
      if (s3_first)
        bin_cnt <= 16'd1;
      else if (bin_cnt == LAST_BIN)
        bin_cnt <= '0;
      else
        bin_cnt <= bin_cnt + 16'd1;
    end
  end

  assign out_valid = s3_valid;
  assign out_mag   = s3_mag;
  assign out_bin   = s3_first ? 16'd0 : bin_cnt;
  assign out_last  = (out_bin == LAST_BIN);
  // A frame start that lands mid-frame is misalignment; it fires only with the accepting handshake.
  assign frame_err = out_fire && s3_first && (bin_cnt != 16'd0);

endmodule
